// File: rtl/stream_width_upsizer.sv
// Serial-to-parallel stream packer: IN_WIDTH-bit beats in, IN_WIDTH*RATIO-bit words out.
// Optional lane-valid mask on m_keep when STREAM_UPSIZER_KEEP_EN is defined.
module stream_width_upsizer #(
    parameter int IN_WIDTH  = 1,
    parameter int RATIO     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_WIDTH-1:0]       s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [IN_WIDTH*RATIO-1:0] m_data,
    output logic                      m_last
`ifdef STREAM_UPSIZER_KEEP_EN
    ,
    output logic [RATIO-1:0]          m_keep
`endif
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] merged;
    logic                 accept;
    logic                 complete;

    always_comb s_ready = ~areset & (~m_valid | m_ready);

    always_comb begin
        accept   = s_valid & s_ready;
        complete = accept & ((cnt == LAST_CNT) | s_last);
    end

    // Lane i is fed by beat index i (LSB-first) or RATIO-1-i (MSB-first).
    always_comb begin
        merged = acc;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CW'((MSB_FIRST != 0) ? (RATIO - 1 - int'(i)) : int'(i)) == cnt)
                merged[i*IN_WIDTH +: IN_WIDTH] = s_data;
        end
    end

`ifdef STREAM_UPSIZER_KEEP_EN
    logic [RATIO-1:0] keep_next;

    // A lane is valid when its beat index is at or below the completing beat.
    always_comb begin
        keep_next = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            keep_next[i] = CW'((MSB_FIRST != 0) ? (RATIO - 1 - int'(i)) : int'(i)) <= cnt;
        end
    end
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt     <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
`ifdef STREAM_UPSIZER_KEEP_EN
            m_keep  <= '0;
`endif
        end else begin
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (accept) begin
                if (complete) begin
                    m_valid <= 1'b1;
                    m_data  <= merged;
                    m_last  <= s_last;
`ifdef STREAM_UPSIZER_KEEP_EN
                    m_keep  <= keep_next;
`endif
                    cnt     <= '0;
                    acc     <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    acc <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_width_upsizer.sv
// Bench for stream_width_upsizer: three configurations driven from shared handshake inputs,
// checked each cycle against a beat-list model plus directed literal expectations.
module tb_stream_width_upsizer;

    logic        clk = 1'b0;
    logic        areset;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_last;
    logic        m_ready;

    logic        sr [3];
    logic        mv [3];
    logic        ml [3];
    logic [15:0] md [3];
    logic [7:0]  mk [3];

    logic        s_ready_0, s_ready_1, s_ready_2;
    logic        m_valid_0, m_valid_1, m_valid_2;
    logic        m_last_0,  m_last_1,  m_last_2;
    logic [7:0]  m_data_0,  m_data_1;
    logic [15:0] m_data_2;
    logic [7:0]  m_keep_0,  m_keep_1;
    logic [3:0]  m_keep_2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // d0: 1-bit beats x8 LSB-first, d1: 1-bit x8 MSB-first, d2: 4-bit x4 LSB-first
    stream_width_upsizer #(.IN_WIDTH(1), .RATIO(8), .MSB_FIRST(0)) d0 (
        .clk(clk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready_0),
        .s_data(s_data[0:0]), .s_last(s_last), .m_valid(m_valid_0), .m_ready(m_ready),
        .m_data(m_data_0), .m_last(m_last_0)
`ifdef STREAM_UPSIZER_KEEP_EN
        , .m_keep(m_keep_0)
`endif
    );

    stream_width_upsizer #(.IN_WIDTH(1), .RATIO(8), .MSB_FIRST(1)) d1 (
        .clk(clk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready_1),
        .s_data(s_data[0:0]), .s_last(s_last), .m_valid(m_valid_1), .m_ready(m_ready),
        .m_data(m_data_1), .m_last(m_last_1)
`ifdef STREAM_UPSIZER_KEEP_EN
        , .m_keep(m_keep_1)
`endif
    );

    stream_width_upsizer #(.IN_WIDTH(4), .RATIO(4), .MSB_FIRST(0)) d2 (
        .clk(clk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready_2),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid_2), .m_ready(m_ready),
        .m_data(m_data_2), .m_last(m_last_2)
`ifdef STREAM_UPSIZER_KEEP_EN
        , .m_keep(m_keep_2)
`endif
    );

`ifndef STREAM_UPSIZER_KEEP_EN
    assign m_keep_0 = '0;
    assign m_keep_1 = '0;
    assign m_keep_2 = '0;
`endif

    assign sr[0] = s_ready_0;
    assign sr[1] = s_ready_1;
    assign sr[2] = s_ready_2;
    assign mv[0] = m_valid_0;
    assign mv[1] = m_valid_1;
    assign mv[2] = m_valid_2;
    assign ml[0] = m_last_0;
    assign ml[1] = m_last_1;
    assign ml[2] = m_last_2;
    assign md[0] = {8'h00, m_data_0};
    assign md[1] = {8'h00, m_data_1};
    assign md[2] = m_data_2;
    assign mk[0] = m_keep_0;
    assign mk[1] = m_keep_1;
    assign mk[2] = {4'h0, m_keep_2};

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned cfg_w(input int d);
        return (d == 2) ? 4 : 1;
    endfunction
    function automatic int unsigned cfg_r(input int d);
        return (d == 2) ? 4 : 8;
    endfunction
    function automatic bit cfg_msb(input int d);
        return d == 1;
    endfunction

    // Model: collect accepted beats into a word value and lane mask; a held output slot.
    logic        e_valid [3];
    logic        e_last  [3];
    int unsigned e_data  [3];
    int unsigned e_keep  [3];
    int unsigned w_acc   [3];
    int unsigned k_acc   [3];
    int unsigned nbeats  [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            e_valid[d] = 1'b0; e_last[d] = 1'b0; e_data[d] = 0; e_keep[d] = 0;
            w_acc[d] = 0; k_acc[d] = 0; nbeats[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (areset) begin
                e_valid[d] = 1'b0; e_last[d] = 1'b0; e_data[d] = 0; e_keep[d] = 0;
                w_acc[d] = 0; k_acc[d] = 0; nbeats[d] = 0;
                chk($sformatf("d%0d_rst_ready", d), sr[d], 0);
                chk($sformatf("d%0d_rst_valid", d), mv[d], 0);
                chk($sformatf("d%0d_rst_data", d), md[d], 0);
            end else begin
                logic        rdy, take, done;
                int unsigned lane;
                rdy = ~e_valid[d] | m_ready;
                chk($sformatf("d%0d_s_ready", d), sr[d], rdy);
                chk($sformatf("d%0d_m_valid", d), mv[d], e_valid[d]);
                chk($sformatf("d%0d_m_data", d), md[d], e_data[d]);
                chk($sformatf("d%0d_m_last", d), ml[d], e_last[d]);
`ifdef STREAM_UPSIZER_KEEP_EN
                chk($sformatf("d%0d_m_keep", d), mk[d], e_keep[d]);
`endif
                take = s_valid & rdy;
                done = 1'b0;
                if (take) begin
                    lane = cfg_msb(d) ? cfg_r(d) - 1 - nbeats[d] : nbeats[d];
                    w_acc[d] |= (int'(s_data) & ((1 << cfg_w(d)) - 1)) << (lane * cfg_w(d));
                    k_acc[d] |= 1 << lane;
                    nbeats[d]++;
                    done = (nbeats[d] == cfg_r(d)) || s_last;
                end
                if (done) begin
                    e_valid[d] = 1'b1;
                    e_data[d]  = w_acc[d];
                    e_last[d]  = s_last;
                    e_keep[d]  = k_acc[d];
                    w_acc[d] = 0; k_acc[d] = 0; nbeats[d] = 0;
                end else if (e_valid[d] && m_ready) begin
                    e_valid[d] = 1'b0;
                end
            end
        end
    end

    task automatic beat(input logic v, input logic [3:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] seq;
        int         pulses;

        areset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_data_d0", md[0], 0);
        chk("reset_valid_d2", mv[2], 0);
        areset = 1'b0;

        // 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first
        seq = 8'h4D;
        for (int i = 0; i < 8; i++) beat(1'b1, {3'b000, seq[i]}, 1'b0);
        s_valid = 1'b0;
        chk("lsb_word", md[0], 32'h4D);
        chk("msb_word", md[1], 32'hB2);
        chk("lsb_valid", mv[0], 1);
        chk("lsb_last", ml[0], 0);
        beat(1'b0, 4'h0, 1'b0);
        chk("lsb_valid_pulse", mv[0], 0);

        // Partial word closed by s_last on the third nibble
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b1, 4'h2, 1'b0);
        beat(1'b1, 4'h3, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        chk("partial_word", md[2], 32'h0321);
        chk("partial_last", ml[2], 1);
`ifdef STREAM_UPSIZER_KEEP_EN
        chk("partial_keep", mk[2], 32'h7);
`endif
        beat(1'b0, 4'h0, 1'b0);

        // Backpressure holds A5, then draining resumes packing at lane 0
        m_ready = 1'b0;
        seq = 8'hA5;
        for (int i = 0; i < 8; i++) beat(1'b1, {3'b000, seq[i]}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", md[0], 32'hA5);
            chk("stall_ready", sr[0], 0);
            beat(1'b1, 4'h1, 1'b0);
        end
        m_ready = 1'b1;
        seq = 8'h3C;
        for (int i = 0; i < 8; i++) beat(1'b1, {3'b000, seq[i]}, 1'b0);
        s_valid = 1'b0;
        chk("resume_word", md[0], 32'h3C);

        // Reset after 5 of 8 beats discards the partial word
        for (int i = 0; i < 5; i++) beat(1'b1, 4'h1, 1'b0);
        s_valid = 1'b0;
        areset = 1'b1;
        #1;
        chk("async_valid", mv[0], 0);
        chk("async_data", md[0], 0);
        chk("async_ready", sr[0], 0);
        @(posedge clk);
        #2;
        areset = 1'b0;
        seq = 8'h02;
        for (int i = 0; i < 8; i++) beat(1'b1, {3'b000, seq[i]}, 1'b0);
        chk("post_reset_word", md[0], 32'h02);

        // 24 continuous beats -> exactly 3 words on the 8-beat ports
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            beat(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            if (mv[0]) pulses++;
        end
        chk("stream_pulses", pulses, 3);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 599) == 0) begin
                s_valid = 1'b0;
                areset = 1'b1;
                @(posedge clk);
                #2;
                areset = 1'b0;
            end else begin
                beat($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 9) == 0);
            end
        end

        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) beat(1'b0, 4'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
